i2s_clk_gen_frac: RTL and testbench
===================================

# i2s_clk_gen_frac

Parametrised I2S/TDM master clock generator for the microphone array front end. It drives the shared BCLK and WS to every microphone, so all capture channels stay phase-locked. A fractional phase accumulator (NCO) derives BCLK from the system clock, which gives an exact long-term 16 kHz Fs from 100 MHz without a PLL. It also supplies per-edge strobes and slot/bit indices that the deserialisers and beamformer front end consume in the system clock domain.

## Interface
Parameters:
- PHASE_W, 32, NCO accumulator width.
- INC_DEFAULT, 87960930, reset increment: round(2·BCLK/F_clk·2^PHASE_W), which is 1.024 MHz BCLK at 100 MHz.
- SLOT_BITS, 32, BCLK cycles per slot (≥2).
- NUM_SLOTS, 2, slots per frame (≥2; 2 = stereo I2S, >2 = TDM).
- WS_MODE, 0, 0 = 50 % duty level WS, 1 = one-BCLK TDM frame-sync pulse.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run request.
- inc_i  in  PHASE_W  new NCO increment.
- inc_load  in  1  one-cycle strobe that stages inc_i.
- bclk  out  1  bit clock to all microphones.
- ws  out  1  word select / frame sync to all microphones.
- bclk_rise  out  1  one-cycle pulse when bclk goes high.
- bclk_fall  out  1  one-cycle pulse when bclk goes low.
- frame_start  out  1  one-cycle pulse at the first bclk_fall of a frame.
- slot_idx  out  clog2(NUM_SLOTS)  current slot.
- bit_idx  out  clog2(SLOT_BITS)  current bit within the slot (0 = MSB).
- running  out  1  generator active.
- frame_cnt  out  32  frame counter; see Configuration.

## Operation
- NCO: acc ← acc + inc_active (mod 2^PHASE_W) every clk while running. A carry-out is a "tick". Each tick toggles bclk, so F_bclk = F_clk·inc/2^(PHASE_W+1).
- inc_active handling:
  - Staged values above 2^(PHASE_W-1) are clamped to 2^(PHASE_W-1), which caps BCLK at clk/4.
  - A staged value of 0 is ignored and the previous increment is kept.
  - A staged increment is applied at the next frame_start, or immediately if the generator is not running.
  - A later inc_load before application overwrites the staged value.
- States: IDLE → RUN → DRAIN → IDLE.
  - IDLE: acc = 0, bclk = 0, counters = 0. Moves to RUN when en = 1.
  - RUN: counters advance on every bclk_fall. bit_idx wraps at SLOT_BITS-1 and increments slot_idx. slot_idx wraps at NUM_SLOTS-1, which starts a new frame.
  - If en drops during RUN, go to DRAIN. DRAIN completes the current frame. At the falling edge that would start the next frame, bclk stays 0, no frame_start is issued, and the state returns to IDLE.
  - If en rises again during DRAIN, go back to RUN with no gap.
- ws updates only on bclk_fall:
  - Mode 0: ws = 1 when slot_idx ≥ NUM_SLOTS/2, otherwise 0.
  - Mode 1: ws = 1 only for bit_idx = 0 of slot 0.
- The one-bit I2S data delay is the deserialiser's responsibility, not this block's.
- The first bclk_fall after entering RUN is frame_start with slot_idx = 0 and bit_idx = 0.

## Timing
- Every output is registered.
- Reset values: bclk = 0, ws = 0, all pulses = 0, slot_idx = 0, bit_idx = 0, running = 0, frame_cnt = 0, acc = 0, inc_active = INC_DEFAULT, state = IDLE.
- rst is synchronous and overrides everything, including mid-frame. Outputs hold reset values in the cycle after rst is sampled high.
- en sampled high in cycle t → running = 1 in cycle t+1. The first tick, a bclk_rise, comes after ceil(2^PHASE_W/inc) further cycles.
- bclk_rise and bclk_fall are high in the same cycle that the new bclk level is visible.
- On a falling edge, ws, slot_idx, bit_idx and frame_start all update in the same cycle as bclk_fall.
- bclk period jitter is ≤1 clk. The long-term rate is exact to increment resolution.
- running drops in the same cycle that the DRAIN→IDLE transition sees no frame_start.

## Configuration
- I2S_CLK_FRAME_CNT_EN:
  - Defined: frame_cnt increments by 1 (wrapping at 2^32) on every frame_start, and clears only on rst. The beamformer uses it to timestamp sample blocks.
  - Undefined: frame_cnt is tied to 0 and no counter logic is built.

## Structure
- Shared package i2s_pkg holds:
  - WS_MODE_LEVEL = 0 and WS_MODE_TDM = 1 constants.
  - The state enum typedef (IDLE, RUN, DRAIN).
  - A function computing an increment from F_clk, F_bclk and PHASE_W.
- One sub-module, i2s_nco: accumulator plus tick output, with inc input and clear. The frame sequencer and WS logic stay in the top module.

## Test plan
- Defaults, en = 1 for 1,000,000 clk → 10,240 ±1 bclk_rise and 160 ±1 frame_start; every bclk half period is 48 or 49 clk.
- inc_i = 2^30 loaded while idle, then en = 1 → bclk period is exactly 8 clk, ws toggles every 256 clk, frame_start every 512 clk, bit_idx runs 0..31 twice per frame.
- inc_load = 2^29 mid-frame → period stays 8 clk until the next frame_start, then 16 clk. A second inc_load before that boundary wins.
- en dropped at slot 1, bit 5 → remaining 26 bits are clocked out, then bclk = 0, ws = 0, running = 0 with no extra pulses. Re-asserting en restarts at slot 0, bit 0.
- NUM_SLOTS = 4, WS_MODE = 1 → ws is high for exactly one BCLK per frame, slot_idx cycles 0,1,2,3. inc_i = 2^31+5 is clamped, giving bclk = clk/4.
- rst pulse mid-frame → next cycle all outputs are at reset values. With I2S_CLK_FRAME_CNT_EN defined, frame_cnt = 3 after three frames, then 0 after rst.

Source files
------------

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared WS modes, sequencer state type and NCO increment helper
package i2s_pkg;

  localparam int WS_MODE_LEVEL = 0;
  localparam int WS_MODE_TDM   = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // round(2 * f_bclk / f_clk * 2^phase_w): one carry per bclk half period
  function automatic logic [63:0] calc_inc(input logic [63:0] f_clk,
                                           input logic [63:0] f_bclk,
                                           input int          phase_w);
    calc_inc = ((f_bclk << (phase_w + 1)) + (f_clk >> 1)) / f_clk;
  endfunction

endpackage

// File: rtl/i2s_nco.sv
// rtl/i2s_nco.sv - phase accumulator whose carry-out marks each bclk edge
module i2s_nco #(
  parameter int PHASE_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               clear_i,
  input  logic [PHASE_W-1:0] inc_i,
  output logic               tick_o
);

  logic [PHASE_W-1:0] acc_q;
  logic [PHASE_W-1:0] acc_d;
  logic [PHASE_W:0]   sum;

  // tick is kept apart from the clear path so the sequencer may derive clear from it
  assign sum    = {1'b0, acc_q} + {1'b0, inc_i};
  assign tick_o = en_i & sum[PHASE_W];

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = sum[PHASE_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/i2s_clk_gen_frac.sv
// rtl/i2s_clk_gen_frac.sv - fractional I2S/TDM bclk/ws master; frame counter built when I2S_CLK_FRAME_CNT_EN is defined
module i2s_clk_gen_frac
  import i2s_pkg::*;
#(
  parameter int                 PHASE_W     = 32,
  parameter logic [PHASE_W-1:0] INC_DEFAULT = PHASE_W'(calc_inc(64'd100_000_000, 64'd1_024_000, PHASE_W)),
  parameter int                 SLOT_BITS   = 32,
  parameter int                 NUM_SLOTS   = 2,
  parameter int                 WS_MODE     = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [PHASE_W-1:0]           inc_i,
  input  logic                         inc_load,
  output logic                         bclk,
  output logic                         ws,
  output logic                         bclk_rise,
  output logic                         bclk_fall,
  output logic                         frame_start,
  output logic [$clog2(NUM_SLOTS)-1:0] slot_idx,
  output logic [$clog2(SLOT_BITS)-1:0] bit_idx,
  output logic                         running,
  output logic [31:0]                  frame_cnt
);

  localparam int                 SLOT_W    = $clog2(NUM_SLOTS);
  localparam int                 BIT_W     = $clog2(SLOT_BITS);
  localparam logic [BIT_W-1:0]   BIT_LAST  = BIT_W'(SLOT_BITS - 1);
  localparam logic [SLOT_W-1:0]  SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [SLOT_W-1:0]  SLOT_HALF = SLOT_W'(NUM_SLOTS / 2);
  localparam logic [PHASE_W-1:0] INC_MAX   = {1'b1, {(PHASE_W-1){1'b0}}};

  state_e              state_q, state_d;
  logic                bclk_q, bclk_d;
  logic                ws_q, ws_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic                fs_q, fs_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                started_q, started_d;
  logic                run_q;
  logic [PHASE_W-1:0]  inc_act_q, inc_act_d;
  logic [PHASE_W-1:0]  inc_stg_q, inc_stg_d;
  logic                stg_vld_q, stg_vld_d;
  logic                tick;
  logic                wrap;
  logic                load_ok;
  logic [PHASE_W-1:0]  inc_clamped;

  i2s_nco #(.PHASE_W(PHASE_W)) u_nco (
    .clk     (clk),
    .rst     (rst),
    .en_i    (state_q != IDLE),
    .clear_i (state_d == IDLE),
    .inc_i   (inc_act_q),
    .tick_o  (tick)
  );

  // the first fall after leaving IDLE and the fall after the last bit both open a frame
  assign wrap = !started_q || ((bit_q == BIT_LAST) && (slot_q == SLOT_LAST));

  always_comb begin
    state_d   = state_q;
    bclk_d    = bclk_q;
    ws_d      = ws_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    fs_d      = 1'b0;
    slot_d    = slot_q;
    bit_d     = bit_q;
    started_d = started_q;
    unique case (state_q)
      IDLE: begin
        bclk_d    = 1'b0;
        ws_d      = 1'b0;
        slot_d    = '0;
        bit_d     = '0;
        started_d = 1'b0;
        if (en) state_d = RUN;
      end
      RUN, DRAIN: begin
        state_d = en ? RUN : DRAIN;
        if (tick && !bclk_q) begin
          bclk_d = 1'b1;
          rise_d = 1'b1;
        end else if (tick) begin
          bclk_d = 1'b0;
          fall_d = 1'b1;
          if (wrap && (state_q == DRAIN) && !en) begin
            state_d   = IDLE;
            slot_d    = '0;
            bit_d     = '0;
            ws_d      = 1'b0;
            started_d = 1'b0;
          end else begin
            started_d = 1'b1;
            if (wrap) begin
              slot_d = '0;
              bit_d  = '0;
              fs_d   = 1'b1;
            end else if (bit_q == BIT_LAST) begin
              bit_d  = '0;
              slot_d = slot_q + 1'b1;
            end else begin
              bit_d  = bit_q + 1'b1;
            end
            if (WS_MODE == WS_MODE_LEVEL) ws_d = (slot_d >= SLOT_HALF);
            else                          ws_d = (slot_d == '0) && (bit_d == '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign inc_clamped = (inc_i > INC_MAX) ? INC_MAX : inc_i;
  assign load_ok     = inc_load && (inc_i != '0);

  // while idle a new increment takes effect at once; otherwise it waits for a frame boundary
  always_comb begin
    inc_act_d = inc_act_q;
    inc_stg_d = inc_stg_q;
    stg_vld_d = stg_vld_q;
    if (load_ok) begin
      inc_stg_d = inc_clamped;
      stg_vld_d = 1'b1;
    end
    if (state_q == IDLE) begin
      if (load_ok) begin
        inc_act_d = inc_clamped;
        stg_vld_d = 1'b0;
      end else if (stg_vld_q) begin
        inc_act_d = inc_stg_q;
        stg_vld_d = 1'b0;
      end
    end else if (fs_d && stg_vld_q) begin
      inc_act_d = inc_stg_q;
      stg_vld_d = load_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bclk_q    <= 1'b0;
      ws_q      <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      fs_q      <= 1'b0;
      slot_q    <= '0;
      bit_q     <= '0;
      started_q <= 1'b0;
      run_q     <= 1'b0;
      inc_act_q <= INC_DEFAULT;
      inc_stg_q <= '0;
      stg_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bclk_q    <= bclk_d;
      ws_q      <= ws_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      fs_q      <= fs_d;
      slot_q    <= slot_d;
      bit_q     <= bit_d;
      started_q <= started_d;
      run_q     <= (state_d != IDLE);
      inc_act_q <= inc_act_d;
      inc_stg_q <= inc_stg_d;
      stg_vld_q <= stg_vld_d;
    end
  end

`ifdef I2S_CLK_FRAME_CNT_EN
  logic [31:0] fcnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q <= '0;
    end else if (fs_d) begin
      fcnt_q <= fcnt_q + 32'd1;
    end
  end

  assign frame_cnt = fcnt_q;
`else
  assign frame_cnt = '0;
`endif

  assign bclk        = bclk_q;
  assign ws          = ws_q;
  assign bclk_rise   = rise_q;
  assign bclk_fall   = fall_q;
  assign frame_start = fs_q;
  assign slot_idx    = slot_q;
  assign bit_idx     = bit_q;
  assign running     = run_q;

endmodule

// File: tb/tb_i2s_clk_gen_frac.sv
// tb/tb_i2s_clk_gen_frac.sv - closed-form reference bench for i2s_clk_gen_frac (stereo and TDM instances)
module tb_i2s_clk_gen_frac;

`ifdef I2S_CLK_FRAME_CNT_EN
  localparam bit FC_ON = 1'b1;
`else
  localparam bit FC_ON = 1'b0;
`endif
  localparam longint INC_DEF = 87960930;
  localparam longint HALF    = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en0 = 1'b0, en1 = 1'b0;
  logic        ld0 = 1'b0, ld1 = 1'b0;
  logic [31:0] inc0 = '0, inc1 = '0;

  logic        bclk0, ws0, rise0, fall0, fs0, running0;
  logic [0:0]  slot0;
  logic [4:0]  bit0;
  logic [31:0] fcnt0;
  logic        bclk1, ws1, rise1, fall1, fs1, running1;
  logic [1:0]  slot1;
  logic [2:0]  bit1;
  logic [31:0] fcnt1;

  longint n_checks = 0;
  longint n_fail   = 0;
  longint fc[2];

  i2s_clk_gen_frac dut0 (
    .clk(clk), .rst(rst), .en(en0), .inc_i(inc0), .inc_load(ld0),
    .bclk(bclk0), .ws(ws0), .bclk_rise(rise0), .bclk_fall(fall0),
    .frame_start(fs0), .slot_idx(slot0), .bit_idx(bit0),
    .running(running0), .frame_cnt(fcnt0)
  );

  i2s_clk_gen_frac #(.SLOT_BITS(8), .NUM_SLOTS(4), .WS_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .inc_i(inc1), .inc_load(ld1),
    .bclk(bclk1), .ws(ws1), .bclk_rise(rise1), .bclk_fall(fall1),
    .frame_start(fs1), .slot_idx(slot1), .bit_idx(bit1),
    .running(running1), .frame_cnt(fcnt1)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint pack(input bit r, input bit b, input bit w, input bit ri,
                                  input bit fa, input bit fs, input longint sl,
                                  input longint bi, input longint fcv);
    return {10'd0, r, b, w, ri, fa, fs, sl[7:0], bi[7:0], fcv[31:0]};
  endfunction

  function automatic longint observe(input int sel);
    if (sel == 0)
      return pack(running0, bclk0, ws0, rise0, fall0, fs0, longint'(slot0), longint'(bit0), longint'(fcnt0));
    return pack(running1, bclk1, ws1, rise1, fall1, fs1, longint'(slot1), longint'(bit1), longint'(fcnt1));
  endfunction

  task automatic do_rst();
    en0 = 1'b0; en1 = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rst_state0", observe(0), 0);
    chk("rst_state1", observe(1), 0);
    rst = 1'b0;
    fc[0] = 0; fc[1] = 0;
  endtask

  task automatic load(input int sel, input logic [31:0] v);
    if (sel != 0) begin inc1 = v; ld1 = 1'b1; end
    else          begin inc0 = v; ld0 = 1'b1; end
    @(negedge clk);
    ld0 = 1'b0; ld1 = 1'b0;
  endtask

  // Edge count after j running cycles is floor(j*inc/2^32); everything else follows from it.
  task automatic run_model(input int sel, input longint inc, input longint ncyc);
    longint t, tp, f, p, sb, ns, sl, bi, fr, e, o;
    bit b, nw, ri, fa, fs, w;
    sb = (sel != 0) ? 8 : 32;
    ns = (sel != 0) ? 4 : 2;
    if (sel != 0) en1 = 1'b1; else en0 = 1'b1;
    tp = 0; fr = 0;
    for (longint j = 0; j < ncyc; j++) begin
      @(negedge clk);
      t  = (j * inc) >> 32;
      b  = t[0];
      nw = (t != tp);
      ri = nw && b;
      fa = nw && !b;
      f  = t >> 1;
      sl = 0; bi = 0; fs = 1'b0; w = 1'b0; fr = 0;
      if (f > 0) begin
        p  = f - 1;
        bi = p % sb;
        sl = (p / sb) % ns;
        fr = p / (sb * ns) + 1;
        fs = fa && ((p % (sb * ns)) == 0);
        w  = (sel != 0) ? (bi == 0 && sl == 0) : (sl >= ns / 2);
      end
      e = pack(1'b1, b, w, ri, fa, fs, sl, bi, FC_ON ? fc[sel] + fr : 0);
      o = observe(sel);
      chk($sformatf("model%0d_j%0d", sel, j), o, e);
      tp = t;
      if (o != e) break;
    end
    fc[sel] += fr;
  endtask

  longint raw, v, fsa, nr, nf, nfs, quiet, expd;
  bit     found, done;
  longint rq[$];
  longint fsq[$];

  initial begin
    fc[0] = 0; fc[1] = 0;
    repeat (3) @(negedge clk);
    do_rst();

    // stereo: default, exact 2^30 (plus an ignored zero load), random (possibly clamped)
    for (int r = 0; r < 3; r++) begin
      do_rst();
      if (r == 0) begin
        v = INC_DEF;
      end else if (r == 1) begin
        load(0, 32'h4000_0000);
        load(0, 32'h0);
        v = 64'h4000_0000;
      end else begin
        raw = longint'($urandom_range(32'hFFFF_FFFF, 32'h0800_0000));
        load(0, raw[31:0]);
        v = (raw > HALF) ? HALF : raw;
      end
      run_model(0, v, (r == 0) ? 13000 : 1200 + longint'($urandom_range(3000, 0)));
    end

    // TDM pulse mode: clamped increment, then a random one
    do_rst();
    load(1, 32'h8000_0005);
    run_model(1, HALF, 600);
    do_rst();
    raw = longint'($urandom_range(32'hFFFF_FFFF, 32'h0800_0000));
    load(1, raw[31:0]);
    run_model(1, (raw > HALF) ? HALF : raw, 2000);

    // increment change mid-frame; the second load must win at the frame boundary
    do_rst();
    load(0, 32'h4000_0000);
    run_model(0, 64'h4000_0000, 300);
    load(0, 32'h1000_0000);
    repeat (20) @(negedge clk);
    load(0, 32'h2000_0000);
    rq.delete(); fsq.delete();
    for (longint c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (rise0) rq.push_back(c);
      if (fs0) fsq.push_back(c);
    end
    chk("incB_fs_count", longint'(fsq.size()), 2);
    if (fsq.size() == 2) begin
      fsa = fsq[0];
      chk("incB_fs_at", fsa, 198);
      chk("incB_frame_len", fsq[1] - fsq[0], 1024);
      for (int i = 1; i < rq.size(); i++) begin
        expd = (rq[i] < fsa) ? 8 : ((rq[i-1] > fsa) ? 16 : 12);
        chk($sformatf("incB_period_%0d", i), rq[i] - rq[i-1], expd);
      end
    end
    fc[0] += 2;

    // drain from slot 1 bit 5
    found = 1'b0;
    for (int c = 0; c < 3000 && !found; c++) begin
      @(negedge clk);
      if (slot0 == 1'b1 && bit0 == 5'd5 && fall0) found = 1'b1;
    end
    chk("drain_find", longint'(found), 1);
    en0 = 1'b0;
    done = 1'b0; nr = 0; nf = 0; nfs = 0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      nr  += longint'(rise0);
      nf  += longint'(fall0);
      nfs += longint'(fs0);
      if (!running0) done = 1'b1;
    end
    chk("drain_done", longint'(done), 1);
    chk("drain_rises", nr, 27);
    chk("drain_falls", nf, 27);
    chk("drain_fs", nfs, 0);
    chk("drain_end", observe(0), pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, FC_ON ? fc[0] : 0));
    quiet = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      quiet += longint'(rise0 | fall0 | fs0 | bclk0 | running0 | ws0);
    end
    chk("idle_quiet", quiet, 0);

    // restart from slot 0 bit 0 with the retained increment
    run_model(0, 64'h2000_0000, 1200);

    // reset mid-frame overrides en and restores the default increment
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid", observe(0), 0);
    rst = 1'b0; en0 = 1'b0;
    fc[0] = 0; fc[1] = 0;
    @(negedge clk);
    run_model(0, INC_DEF, 300);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
